// File: rtl/gate_tester.sv
// Stimulus/response engine for 2-input gate primitives: walks the four input
// vectors, samples dut_y after a settle delay and scores it against a truth table.
module gate_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       sel_legal;
    logic       mismatch;

    function automatic logic expected_y(input logic [2:0] sel, input logic a, input logic b);
        logic y;
        case (sel)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = ~(a & b);
            3'd3:    y = ~(a | b);
            3'd4:    y = a ^ b;
            3'd5:    y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    assign sel_legal = (gate_sel <= 3'd5);
    assign mismatch  = (dut_y != expected_y(sel_q, a_q, b_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = sel_legal ? S_APPLY : S_DONE;
                end
            end
            S_APPLY: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = (idx_q == 2'd3) ? S_DONE : S_APPLY;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: vector index, settle counter and result registers
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        err_d  = err_q;
        fail_d = fail_q;
        pass_d = pass_q;
        a_d    = a_q;
        b_d    = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = gate_sel;
                    err_d  = 3'd0;
                    fail_d = sel_legal ? 4'b0000 : 4'b1111;
                    pass_d = 1'b0;
                    idx_d  = 2'd0;
                    a_d    = 1'b0;
                    b_d    = 1'b0;
                end
            end
            S_APPLY: cnt_d = SETTLE_INIT;
            S_WAIT:  cnt_d = cnt_q - 8'd1;
            S_CHECK: begin
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    // Final verdict is registered on entry to DONE so it is valid with done
                    pass_d = !mismatch && (err_q == 3'd0);
                end else begin
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                idx_d = 2'd0;
                a_d   = 1'b0;
                b_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_APPLY, S_WAIT, S_CHECK: busy = 1'b1;
            S_DONE:                   done = 1'b1;
            default: ;
        endcase
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Randomized bench for gate_tester: a truth-table gate model drives dut_y and a
// per-run reference computes timing, vector order and the expected verdict.
module tb_gate_tester;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [2:0] sel0, sel1;
    logic [3:0] tt0, tt1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate under test modelled as a 4-entry truth table indexed by {a,b}
    assign y0 = tt0[{a0, b0}];
    assign y1 = tt1[{a1, b1}];

    gate_tester #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .gate_sel(sel0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    gate_tester #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(sel1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_tt(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_reset0(input string pfx);
        check_eq({pfx, "_a"},    32'(a0),    32'd0);
        check_eq({pfx, "_b"},    32'(b0),    32'd0);
        check_eq({pfx, "_busy"}, 32'(busy0), 32'd0);
        check_eq({pfx, "_done"}, 32'(done0), 32'd0);
        check_eq({pfx, "_pass"}, 32'(pass0), 32'd0);
        check_eq({pfx, "_err"},  32'(err0),  32'd0);
        check_eq({pfx, "_fail"}, 32'(fail0), 32'd0);
    endtask

    // One run on u_dut0; pulse_c/rst_c (0 = none) inject start or reset during that cycle
    task automatic run(input logic [2:0] sel, input logic [3:0] tt, input int pulse_c, input int rst_c);
        logic       legal;
        logic [3:0] exp_fail;
        int         exp_err;
        logic       exp_pass;
        int         n;
        logic [1:0] vec;
        legal    = (sel <= 3'd5);
        n        = legal ? 1 + 4 * (S0 + 2) : 1;
        exp_fail = legal ? (tt ^ ref_tt(sel)) : 4'b1111;
        exp_err  = legal ? $countones(exp_fail) : 0;
        exp_pass = legal && (exp_err == 0);
        @(negedge clk);
        tt0    = tt;
        sel0   = sel;
        start0 = 1'b1;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
            if (pulse_c != 0 && c == pulse_c + 1) start0 = 1'b0;
            if (rst_c != 0 && c == rst_c + 1) begin
                rst_n = 1'b1;
                check_reset0("midrun_rst");
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    check_eq("no_done_after_rst", 32'(done0), 32'd0);
                    check_eq("idle_after_rst", 32'(busy0), 32'd0);
                end
                return;
            end
            check_eq("busy", 32'(busy0), 32'(c < n));
            check_eq("done", 32'(done0), 32'(c == n));
            if (c < n) begin
                vec = 2'((c - 1) / (S0 + 2));
                check_eq("vector_ab", 32'({a0, b0}), 32'(vec));
            end
            if (c >= n) begin
                check_eq("pass", 32'(pass0), 32'(exp_pass));
                check_eq("err_count", 32'(err0), 32'(exp_err));
                check_eq("fail_vec", 32'(fail0), 32'(exp_fail));
            end
            if (c == n + 1) check_eq("ab_idle", 32'({a0, b0}), 32'd0);
            if (c == pulse_c) start0 = 1'b1;
            if (c == rst_c) rst_n = 1'b0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        sel0   = 3'd0;
        sel1   = 3'd4;
        tt0    = 4'b1000;
        tt1    = 4'b0110;
        repeat (3) @(negedge clk);
        check_reset0("reset");
        check_eq("reset_busy1", 32'(busy1), 32'd0);
        check_eq("reset_done1", 32'(done1), 32'd0);
        rst_n = 1'b1;

        run(3'd0, 4'b1000, 0, 0);
        run(3'd0, 4'b0000, 0, 0);
        run(3'd1, 4'b1000, 0, 0);
        run(3'd4, 4'b1000, 0, 0);
        run(3'd2, 4'b0111, 0, 0);
        run(3'd0, 4'b1000, 6, 0);
        run(3'd0, 4'b0001, 0, 10);
        run(3'd7, 4'b1000, 0, 0);
        run(3'd6, 4'b0110, 0, 0);
        repeat (24) begin
            run(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 0, 0);
        end

        // Continuous start on the SETTLE_CYCLES=1 instance: 14-cycle run period
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 40) start1 = 1'b0;
            check_eq("b2b_done", 32'(done1), 32'(c == 13 || c == 27 || c == 41));
            check_eq("b2b_busy", 32'(busy1), 32'(c <= 40 && ((c - 1) % 14) < 12));
            if (c == 13 || c == 27 || c == 41) begin
                check_eq("b2b_pass", 32'(pass1), 32'd1);
                check_eq("b2b_err", 32'(err1), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
